tctsu_sequencer: RTL and testbench
==================================

# tctsu_sequencer

Timing-control sequencer for the computer datapath. It counts major/minor cycles against the digit-pulse clock and drives the computer's gates for multiply and shift orders:
- odd/even cycle gates (`g1_pos`/`g1_neg`)
- shifting gate (`g2_pos`/`g2_neg`)
- multiplier digit-test pulse `dx`
- right-shift sign-test pulse `ds`

It sits between the Main Control Unit, which starts it in stage 2, and the computer subsystem. It returns a completion pulse to main control.

## Interface
Parameters:
- `SHORT_ITERS`, 17: multiply iterations for a short-word order.
- `LONG_ITERS`, 35: multiply iterations for a long-word order.
- `DIGITS`, 36: digit clocks per cycle, d0 to next d0.

Ports:
- `clk`  in  1  digit clock.
- `rst`  in  1  asynchronous, active-high reset.
- `d0`  in  1  digit-0 pulse; one clock per cycle.
- `d17`  in  1  digit-17 pulse.
- `start`  in  1  one-clock start from main control (g13 qualified).
- `c7`  in  1  right-shift order.
- `c8`  in  1  left-shift order.
- `c9`  in  1  multiply order (X/Y).
- `f1_neg`  in  1  0 = long-word order, 1 = short-word order.
- `shift_n`  in  5  shift count from the order address field.
- `g1_pos`  out  1  odd-cycle gate.
- `g1_neg`  out  1  even-cycle gate.
- `g2_pos`  out  1  shifting gate.
- `g2_neg`  out  1  complement of `g2_pos` while busy.
- `dx`  out  1  multiplier digit-test pulse.
- `ds`  out  1  right-shift sign-test pulse.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-clock completion pulse.

## Operation
- FSM states:
  - IDLE
  - ARM: waiting for d0.
  - RUN
  - FIN
- IDLE → ARM on `start`. On this transition latch the order: `op` = MUL if `c9`, else RSH if `c7`, else LSH if `c8`, else NUL. Also latch `shift_n`, and `long = ~f1_neg`.
- NUL → FIN directly on the next clock. No gates are asserted.
- ARM → RUN on the first `d0` sampled strictly after the `start` clock. A `d0` coincident with `start` does not count.
- RUN:
  - Iteration counter `it` = 0 at entry; it increments on each subsequent `d0`.
  - Limit N is:
    - MUL: `LONG_ITERS` if `long`, else `SHORT_ITERS`.
    - shifts: `shift_n`; `shift_n` = 0 is treated as 32.
  - When the `d0` arrives with `it` = N−1, go to FIN.
- FIN → IDLE after one clock. `done` = 1 while in FIN.
- Digit counter `dpos`:
  - 6 bits; cleared on `d0`, otherwise increments.
  - Saturates at `DIGITS`−1 if `d0` is missing.
- MUL gates:
  - `g1_pos` when `it` is odd, `g1_neg` when `it` is even.
  - `dx` one clock when `dpos` == `it`, i.e. the multiplier LSB is tested first.
- Shift gates:
  - `g2_pos` for all of RUN; `g2_neg` = `busy & ~g2_pos`.
  - `ds` one clock at `d17` of every RSH cycle; never for LSH.
- `start` while not IDLE is ignored. The latched order is unchanged.
- `rst` at any time:
  - Returns the FSM to IDLE and clears `it`, `dpos` and the latches.
  - All outputs go to 0 immediately; no `done` is produced.
- Reset value of every output: 0. `g2_neg` is 0 in IDLE.

## Timing
- All outputs are registered and lag the digit they refer to by exactly one clock. The computer's gating is aligned to this.
- Gates rise the clock after the entry `d0` is sampled. They fall the clock after the terminating `d0`. Each gate therefore spans exactly N×`DIGITS` clocks.
- `done` is high in the clock after gates fall. `busy` is high from the clock after `start` until `done`, inclusive.
- Latency from `start` to `done` = (wait for `d0`) + N×`DIGITS` + 2 clocks. For NUL it is 2 clocks.
- One `dx` pulse per MUL iteration: N pulses total, at digit positions 0..N−1.

## Configuration
- `TCTSU_LONG_EN` defined: `f1_neg` selects `LONG_ITERS` or `SHORT_ITERS` for MUL.
- `TCTSU_LONG_EN` undefined: `f1_neg` is ignored, MUL always uses `SHORT_ITERS`, and the `long` latch is not built.

## Structure
- Shared package `edsac_pkg`:
  - FSM state enum.
  - Op enum (NUL/MUL/RSH/LSH).
  - `DIGITS`, `SHORT_ITERS`, `LONG_ITERS` constants.
- One sub-module, `digit_counter`, holds `dpos` (clear on `d0`, saturate). It is reused by the CCU.

## Test plan
- MUL short (`c9`=1, `f1_neg`=1):
  - `done` arrives 17×36+2 clocks after the first `d0`.
  - 17 `dx` pulses at `dpos` 0..16.
  - `g1_neg` in iterations 0,2,…,16; `g1_pos` in iterations 1,…,15.
- MUL long (`f1_neg`=0, `TCTSU_LONG_EN` on): 35 `dx` pulses. With the macro off: 17 pulses.
- RSH with `shift_n`=3:
  - `g2_pos` high for 108 clocks.
  - Three `ds` pulses, each one clock after `d17`.
  - LSH with the same count produces no `ds`.
- `shift_n`=0 with LSH: `g2_pos` high for 32×36 clocks.
- `start` coincident with `d0`: RUN begins at the following `d0`. A second `start` mid-RUN has no effect.
- `rst` asserted in RUN at iteration 5: all outputs 0 the same clock and no `done`. A new `start` then runs a full sequence.

Source files
------------

// File: rtl/edsac_pkg.sv
// Shared types and constants for the EDSAC timing-control and main-control blocks.
package edsac_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun,
    StFin
  } state_e;

  typedef enum logic [1:0] {
    OpNul,
    OpMul,
    OpRsh,
    OpLsh
  } op_e;

  localparam int unsigned DIGITS      = 36;
  localparam int unsigned SHORT_ITERS = 17;
  localparam int unsigned LONG_ITERS  = 35;
  localparam int unsigned DposW       = 6;

endpackage

// File: rtl/digit_counter.sv
// Digit position within the current cycle: 0 on the d0 clock, then counts up and
// holds at DIGITS-1 if d0 goes missing.
module digit_counter
  import edsac_pkg::*;
#(
  parameter int unsigned DIGITS = edsac_pkg::DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d0,
  output logic [DposW-1:0] dpos
);

  logic [DposW-1:0] r_cnt;

  assign dpos = d0 ? '0 : r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (dpos == DposW'(DIGITS - 1)) begin
      r_cnt <= dpos;
    end else begin
      r_cnt <= dpos + DposW'(1);
    end
  end

endmodule

// File: rtl/tctsu_sequencer.sv
// Timing-control sequencer for multiply and shift orders.
// Optional feature macro: TCTSU_LONG_EN (long-word multiply via f1_neg).
module tctsu_sequencer
  import edsac_pkg::*;
#(
  parameter int unsigned SHORT_ITERS = edsac_pkg::SHORT_ITERS,
  parameter int unsigned LONG_ITERS  = edsac_pkg::LONG_ITERS,
  parameter int unsigned DIGITS      = edsac_pkg::DIGITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d0,
  input  logic       d17,
  input  logic       start,
  input  logic       c7,
  input  logic       c8,
  input  logic       c9,
  input  logic       f1_neg,
  input  logic [4:0] shift_n,
  output logic       g1_pos,
  output logic       g1_neg,
  output logic       g2_pos,
  output logic       g2_neg,
  output logic       dx,
  output logic       ds,
  output logic       busy,
  output logic       done
);

  state_e           r_state, w_state_d;
  op_e              r_op, w_op_dec;
  logic [4:0]       r_shift;
  logic [5:0]       r_it, w_it_d, w_cur_it, w_limit;
  logic [DposW-1:0] w_dpos;
  logic             w_long, w_accept, w_run;
  logic             w_g1_pos, w_g1_neg, w_g2_pos, w_g2_neg, w_dx, w_ds, w_busy, w_done;
  logic             r_g1_pos, r_g1_neg, r_g2_pos, r_g2_neg, r_dx, r_ds, r_busy, r_done;

  digit_counter #(
    .DIGITS(DIGITS)
  ) u_digit_counter (
    .clk (clk),
    .rst (rst),
    .d0  (d0),
    .dpos(w_dpos)
  );

  assign w_accept = (r_state == StIdle) && start;

`ifdef TCTSU_LONG_EN
  logic r_long;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_long <= 1'b0;
    end else if (w_accept) begin
      r_long <= ~f1_neg;
    end
  end
  assign w_long = r_long;
`else
  logic w_unused_f1_neg;
  assign w_unused_f1_neg = f1_neg;
  assign w_long          = 1'b0;
`endif

  always_comb begin
    w_op_dec = OpNul;
    if (c9)      w_op_dec = OpMul;
    else if (c7) w_op_dec = OpRsh;
    else if (c8) w_op_dec = OpLsh;
  end

  always_comb begin
    w_limit = 6'd32;
    if (r_op == OpMul)      w_limit = w_long ? 6'(LONG_ITERS) : 6'(SHORT_ITERS);
    else if (r_shift != '0) w_limit = {1'b0, r_shift};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= OpNul;
      r_shift <= '0;
      r_it    <= '0;
    end else begin
      r_state <= w_state_d;
      r_it    <= w_it_d;
      if (w_accept) begin
        r_op    <= w_op_dec;
        r_shift <= shift_n;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_it_d    = r_it;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = (w_op_dec == OpNul) ? StFin : StArm;
          w_it_d    = '0;
        end
      end
      StArm: begin
        if (d0) begin
          w_state_d = StRun;
          w_it_d    = '0;
        end
      end
      StRun: begin
        if (d0) begin
          if (r_it == w_limit - 6'd1) begin
            w_state_d = StFin;
            w_it_d    = '0;
          end else begin
            w_it_d = r_it + 6'd1;
          end
        end
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs describe the digit on the wire this clock and appear one clock later.
  assign w_cur_it = ((r_state == StRun) && d0) ? r_it + 6'd1 : r_it;
  assign w_run    = (w_state_d == StRun);
  assign w_g1_pos = w_run && (r_op == OpMul) && w_cur_it[0];
  assign w_g1_neg = w_run && (r_op == OpMul) && !w_cur_it[0];
  assign w_dx     = w_run && (r_op == OpMul) && (w_dpos == w_cur_it);
  assign w_g2_pos = w_run && ((r_op == OpRsh) || (r_op == OpLsh));
  assign w_ds     = w_run && (r_op == OpRsh) && d17;
  assign w_busy   = (w_state_d != StIdle) || (r_state == StFin);
  assign w_done   = (r_state == StFin);
  assign w_g2_neg = w_busy && !w_g2_pos;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_g1_pos <= 1'b0;
      r_g1_neg <= 1'b0;
      r_g2_pos <= 1'b0;
      r_g2_neg <= 1'b0;
      r_dx     <= 1'b0;
      r_ds     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_g1_pos <= w_g1_pos;
      r_g1_neg <= w_g1_neg;
      r_g2_pos <= w_g2_pos;
      r_g2_neg <= w_g2_neg;
      r_dx     <= w_dx;
      r_ds     <= w_ds;
      r_busy   <= w_busy;
      r_done   <= w_done;
    end
  end

  assign g1_pos = r_g1_pos;
  assign g1_neg = r_g1_neg;
  assign g2_pos = r_g2_pos;
  assign g2_neg = r_g2_neg;
  assign dx     = r_dx;
  assign ds     = r_ds;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_tctsu_sequencer.sv
// Scoreboard bench for tctsu_sequencer: expectations queued at start, checked at done.
module tb_tctsu_sequencer;

  logic       clk, rst, d0, d17, start, c7, c8, c9, f1_neg;
  logic [4:0] shift_n;
  logic       g1_pos, g1_neg, g2_pos, g2_neg, dx, ds, busy, done;

  tctsu_sequencer dut (
    .clk    (clk),
    .rst    (rst),
    .d0     (d0),
    .d17    (d17),
    .start  (start),
    .c7     (c7),
    .c8     (c8),
    .c9     (c9),
    .f1_neg (f1_neg),
    .shift_n(shift_n),
    .g1_pos (g1_pos),
    .g1_neg (g1_neg),
    .g2_pos (g2_pos),
    .g2_neg (g2_neg),
    .dx     (dx),
    .ds     (ds),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    int done_cyc;
    int busy_len;
    int n_dx;
    int n_ds;
    int g1p;
    int g1n;
    int g2p;
    int g2n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ph = 0;
  int   last_k = 0;

  int a_busy, a_dx, a_ds, a_g1p, a_g1n, a_g2p, a_g2n, a_poserr;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic int iters(input logic m, input logic r, input logic l, input logic f1n,
                               input logic [4:0] sn);
    if (m) begin
`ifdef TCTSU_LONG_EN
      return f1n ? 17 : 35;
`else
      return 17;
`endif
    end
    if (r || l) return (sn == 0) ? 32 : int'(sn);
    return 0;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Digit-pulse source: one d0 every 36 clocks, d17 seventeen clocks later.
  initial begin
    d0  = 1;
    d17 = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ph  = (ph + 1) % 36;
      d0  = (ph == 0);
      d17 = (ph == 17);
    end
  end

  task automatic clear_acc();
    a_busy = 0; a_dx = 0; a_ds = 0; a_g1p = 0; a_g1n = 0; a_g2p = 0; a_g2n = 0; a_poserr = 0;
  endtask

  initial begin
    exp_t e;
    clear_acc();
    forever begin
      @(negedge clk);
      if (rst) begin
        clear_acc();
      end else begin
        if (busy)   a_busy++;
        if (g1_pos) a_g1p++;
        if (g1_neg) a_g1n++;
        if (g2_pos) a_g2p++;
        if (g2_neg) a_g2n++;
        if (dx) begin
          if (((ph + 35) % 36) != a_dx) a_poserr++;
          a_dx++;
        end
        if (ds) begin
          if (ph != 18) a_poserr++;
          a_ds++;
        end
        if (done) begin
          if (q.size() == 0) begin
            check_eq("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check_eq("done_cyc", cyc, e.done_cyc);
            check_eq("busy_len", a_busy, e.busy_len);
            check_eq("dx_cnt", a_dx, e.n_dx);
            check_eq("ds_cnt", a_ds, e.n_ds);
            check_eq("g1pos_len", a_g1p, e.g1p);
            check_eq("g1neg_len", a_g1n, e.g1n);
            check_eq("g2pos_len", a_g2p, e.g2p);
            check_eq("g2neg_len", a_g2n, e.g2n);
            check_eq("pulse_pos", a_poserr, 0);
          end
          clear_acc();
        end
      end
    end
  end

  task automatic wait_ph(input int p);
    do begin
      @(posedge clk);
      #2;
    end while (ph != p);
  endtask

  // Called at posedge+#2; start is presented for exactly this cycle.
  task automatic drive_start(input logic m, input logic r, input logic l, input logic f1n,
                             input logic [4:0] sn);
    exp_t e;
    int   s, n, k;
    logic em, er, el;
    c9 = m; c7 = r; c8 = l; f1_neg = f1n; shift_n = sn; start = 1;
    s  = cyc;
    em = m;
    er = !m && r;
    el = !m && !r && l;
    n  = iters(em, er, el, f1n, sn);
    if (!(em || er || el)) begin
      e.done_cyc = s + 2;
    end else begin
      k          = s + 36 - ph;
      last_k     = k;
      e.done_cyc = k + n * 36 + 2;
    end
    e.busy_len = e.done_cyc - s;
    e.n_dx     = em ? n : 0;
    e.n_ds     = er ? n : 0;
    e.g1n      = em ? ((n + 1) / 2) * 36 : 0;
    e.g1p      = em ? (n / 2) * 36 : 0;
    e.g2p      = (er || el) ? n * 36 : 0;
    e.g2n      = e.busy_len - e.g2p;
    q.push_back(e);
    @(posedge clk);
    #2;
    start = 0; c9 = 0; c7 = 0; c8 = 0; f1_neg = 1; shift_n = '0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check_eq("timeout", q.size(), 0);
      q.delete();
    end
    repeat (5) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1; start = 0; c7 = 0; c8 = 0; c9 = 0; f1_neg = 1; shift_n = '0;
    repeat (3) @(posedge clk);
    #2;
    check_eq("reset_outs", int'({g1_pos, g1_neg, g2_pos, g2_neg, dx, ds, busy, done}), 0);
    rst = 0;
    repeat (40) @(posedge clk);

    // MUL short; c7 also set to exercise order priority.
    wait_ph(5);
    drive_start(1, 1, 0, 1, 5'd0);
    wait_done();
    // MUL long word.
    wait_ph(20);
    drive_start(1, 0, 0, 0, 5'd0);
    wait_done();
    // RSH 3, LSH 3, LSH 0 (=32), NUL.
    wait_ph(30);
    drive_start(0, 1, 0, 1, 5'd3);
    wait_done();
    wait_ph(11);
    drive_start(0, 0, 1, 1, 5'd3);
    wait_done();
    wait_ph(1);
    drive_start(0, 0, 1, 1, 5'd0);
    wait_done();
    wait_ph(9);
    drive_start(0, 0, 0, 1, 5'd7);
    wait_done();

    // Start coincident with d0, plus an ignored start mid-run.
    wait_ph(0);
    drive_start(1, 0, 0, 1, 5'd0);
    repeat (200) @(posedge clk);
    #2;
    start = 1; c7 = 1; shift_n = 5'd5;
    @(posedge clk);
    #2;
    start = 0; c7 = 0; shift_n = '0;
    wait_done();

    // Reset during MUL iteration 5: everything drops at once, no done.
    wait_ph(14);
    drive_start(1, 0, 0, 1, 5'd0);
    while (cyc < last_k + 5 * 36 + 10) begin
      @(posedge clk);
      #2;
    end
    check_eq("busy_before_rst", int'(busy), 1);
    check_eq("g1_before_rst", int'(g1_pos | g1_neg), 1);
    rst = 1;
    #1;
    check_eq("rst_outs", int'({g1_pos, g1_neg, g2_pos, g2_neg, dx, ds, busy, done}), 0);
    q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    repeat (80) @(posedge clk);
    #2;
    check_eq("idle_after_rst", int'({g1_pos, g1_neg, g2_pos, g2_neg, dx, ds, busy, done}), 0);
    wait_ph(25);
    drive_start(0, 1, 0, 1, 5'd3);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
